// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared AES-128 encryption definitions: FSM state encoding, round count,
// round-constant table and the GF(2^8) helpers used by MixColumns.
// ---------------------------------------------------------------------------
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Number of rounds for a 128-bit key.
  localparam logic [3:0] NR = 4'd10;

  // Round constant for rounds 1..NR; other indices are never used.
  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    logic [7:0] r;
    case (rnd)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // MixColumns on one column; byte [31:24] is row 0.
  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    // 3*a is written as xtime(a) ^ a
    b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {b0, b1, b2, b3};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// ---------------------------------------------------------------------------
// aes_sbox
// Combinational AES forward S-box.
//   i_in  [7:0]  byte to substitute
//   o_out [7:0]  substituted byte
// ---------------------------------------------------------------------------
module aes_sbox (
  input  logic [7:0] i_in,
  output logic [7:0] o_out
);

  // Entry 0 sits in the top byte, so entry i is at bit offset (255-i)*8,
  // and 255-i is simply ~i for an 8-bit index.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign o_out = SBOX[{~i_in, 3'b000} +: 8];

endmodule

// File: rtl/aes_enc_core.sv
// ---------------------------------------------------------------------------
// aes_enc_core
// Iterative AES-128 encryptor: one round per clock, round keys expanded on
// the fly. A block takes 11 cycles from the start edge to the done pulse,
// and a start during DONE chains the next block with no idle cycle.
//   clk         system clock
//   reset       asynchronous, active-high reset
//   start       encrypt request (ignored while busy)
//   key         cipher key, w[0] in [127:96]
//   plaintext   input block, byte S0,0 in [127:120], column-major
//   busy        high while rounds are running
//   done        one-cycle pulse, cyphertext valid
//   cyphertext  result block, held until the next block finishes
// ---------------------------------------------------------------------------
module aes_enc_core
  import aes_pkg::*;
#(
  parameter int K = 128
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [K-1:0]   key,
  input  logic [127:0]   plaintext,
  output logic           busy,
  output logic           done,
  output logic [127:0]   cyphertext
);

  if (K != 128) begin : g_bad_k
    $error("aes_enc_core: only K=128 is supported");
  end

  state_t       r_fsm;
  state_t       w_fsm_nxt;
  logic [3:0]   r_round;
  logic [127:0] r_state;
  logic [127:0] r_key;      // round key of the previous round
  logic [127:0] r_ct;

  logic         w_load;
  logic         w_step;
  logic         w_last;

  logic [127:0] w_sub;
  logic [127:0] w_sr;
  logic [127:0] w_mc;
  logic [31:0]  w_rot;
  logic [31:0]  w_subw;
  logic [127:0] w_nkey;
  logic [127:0] w_next;

  // ---------------- SubBytes ----------------
  for (genvar g = 0; g < 16; g++) begin : g_sb
    aes_sbox u_sbox (
      .i_in  (r_state[127-8*g -: 8]),
      .o_out (w_sub[127-8*g -: 8])
    );
  end

  // ---------------- ShiftRows ----------------
  // Row r of column c takes row r of column (c+r) mod 4.
  for (genvar c = 0; c < 4; c++) begin : g_sr_c
    for (genvar r = 0; r < 4; r++) begin : g_sr_r
      assign w_sr[127-8*(4*c+r) -: 8] = w_sub[127-8*(4*((c+r)%4)+r) -: 8];
    end
  end

  // ---------------- MixColumns ----------------
  for (genvar c = 0; c < 4; c++) begin : g_mc
    assign w_mc[127-32*c -: 32] = mix_col(w_sr[127-32*c -: 32]);
  end

  // ---------------- Key expansion ----------------
  assign w_rot = {r_key[23:0], r_key[31:24]};

  for (genvar j = 0; j < 4; j++) begin : g_sw
    aes_sbox u_sbox (
      .i_in  (w_rot[31-8*j -: 8]),
      .o_out (w_subw[31-8*j -: 8])
    );
  end

  assign w_nkey[127:96] = r_key[127:96] ^ w_subw ^ {rcon(r_round), 24'h0};
  assign w_nkey[95:64]  = w_nkey[127:96] ^ r_key[95:64];
  assign w_nkey[63:32]  = w_nkey[95:64]  ^ r_key[63:32];
  assign w_nkey[31:0]   = w_nkey[63:32]  ^ r_key[31:0];

  // ---------------- AddRoundKey ----------------
  // The final round skips MixColumns.
  assign w_next = ((r_round == NR) ? w_sr : w_mc) ^ w_nkey;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_fsm <= ST_IDLE;
    else       r_fsm <= w_fsm_nxt;
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      ST_IDLE,
      ST_DONE:  w_fsm_nxt = start ? ST_ROUND : ST_IDLE;
      ST_ROUND: if (r_round == NR) w_fsm_nxt = ST_DONE;
      default:  w_fsm_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy   = 1'b0;
    done   = 1'b0;
    w_load = 1'b0;
    w_step = 1'b0;
    w_last = 1'b0;
    case (r_fsm)
      ST_IDLE:  w_load = start;
      ST_DONE: begin
        done   = 1'b1;
        w_load = start;
      end
      ST_ROUND: begin
        busy   = 1'b1;
        w_step = 1'b1;
        w_last = (r_round == NR);
      end
      default: ;
    endcase
  end

  // ---------------- Datapath ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_round <= 4'd0;
      r_state <= '0;
      r_key   <= '0;
      r_ct    <= '0;
    end else if (w_load) begin
      r_key   <= key;
      r_state <= plaintext ^ key;
      r_round <= 4'd1;
    end else if (w_step) begin
      r_state <= w_next;
      r_key   <= w_nkey;
      // Counter parks at NR after the last round so it never leaves 1..10.
      if (w_last) r_ct    <= w_next;
      else        r_round <= r_round + 4'd1;
    end
  end

  assign cyphertext = r_ct;

endmodule

// File: tb/tb_aes_enc_core.sv
module tb_aes_enc_core;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [127:0] key = '0;
  logic [127:0] plaintext = '0;
  logic         busy, done;
  logic [127:0] cyphertext;

  int checks = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KC = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PC = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CZ = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  aes_enc_core #(.K(128)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .key        (key),
    .plaintext  (plaintext),
    .busy       (busy),
    .done       (done),
    .cyphertext (cyphertext)
  );

  always #5 clk = ~clk;

  // ---------------- reference AES ----------------
  logic [7:0] sb [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box from its definition: inverse in GF(2^8) (x^254), then affine map.
  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] p, inv;
    p = x;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gmul(p, p);
      inv = gmul(inv, p);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] p);
    logic [31:0] w [44];
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [31:0] tmp;
    logic [7:0]  rc, a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]};
        tmp[31:24] = tmp[31:24] ^ rc;
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) s[4*c+r] = s[4*c+r] ^ w[c][31-8*r -: 8];
    for (int rd = 1; rd <= 10; rd++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[4*c+r] = t[4*((c+r)%4)+r];
      if (rd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[4*c+r] = s[4*c+r] ^ w[4*rd+c][31-8*r -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  // ---------------- cycle model ----------------
  // phase 0 idle, 1..10 busy, 11 done; result computed at the accepting edge.
  int           m_phase = 0;
  logic [127:0] m_pend = '0;
  logic [127:0] m_ct = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase <= 0;
      m_ct    <= '0;
    end else if (m_phase == 0 || m_phase == 11) begin
      if (start) begin
        m_phase <= 1;
        m_pend  <= aes_ref(key, plaintext);
      end else begin
        m_phase <= 0;
      end
    end else if (m_phase == 10) begin
      m_phase <= 11;
      m_ct    <= m_pend;
    end else begin
      m_phase <= m_phase + 1;
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_busy", 128'(busy), 128'(m_phase >= 1 && m_phase <= 10));
      chk("cyc_done", 128'(done), 128'(m_phase == 11));
      chk("cyc_ct", cyphertext, m_ct);
    end
  end

  // Called at a negedge; returns at the negedge where done is seen.
  task automatic run(input logic [127:0] k, input logic [127:0] p,
                     input logic [127:0] c, input string nm);
    int n;
    key = k;
    plaintext = p;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_latency"}, 128'(n), 128'd10);
    chk({nm, "_ct"}, cyphertext, c);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n, nd;
    for (int x = 0; x < 256; x++) sb[x] = sbox_ref(8'(x));

    // Pin the reference model to published vectors.
    chk("ref_B", aes_ref(KB, PB), CB);
    chk("ref_C1", aes_ref(KC, PC), CC);
    chk("ref_zero", aes_ref('0, '0), CZ);

    #1 reset = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_ct", cyphertext, 128'd0);

    // Start on the very first edge after reset release.
    reset = 1'b0;
    run(KB, PB, CB, "B_first");
    repeat (3) @(negedge clk);

    // C.1 then back-to-back App. B started during DONE.
    run(KC, PC, CC, "C1");
    key = KB;
    plaintext = PB;
    start = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      n++;
    end while (!done && n < 30);
    chk("b2b_gap", 128'(n), 128'd11);
    chk("b2b_ct", cyphertext, CB);
    repeat (3) @(negedge clk);

    // Hold start and scramble inputs while busy.
    key = KC;
    plaintext = PC;
    start = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!done) begin
        key = {$urandom(), $urandom(), $urandom(), $urandom()};
        plaintext = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
    end while (!done && n < 30);
    start = 1'b0;
    chk("hold_latency", 128'(n), 128'd11);
    chk("hold_ct", cyphertext, CC);
    nd = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("hold_extra_done", 128'(nd), 128'd0);

    // Reset while round 5 is in progress.
    key = KB;
    plaintext = PB;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", 128'(busy), 128'd0);
    chk("abort_done", 128'(done), 128'd0);
    chk("abort_ct", cyphertext, 128'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    nd = 0;
    repeat (14) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("abort_no_done", 128'(nd), 128'd0);
    run(KB, PB, CB, "B_rerun");
    repeat (2) @(negedge clk);

    // All-zero vector, then output must hold through idle cycles.
    run('0, '0, CZ, "zero");
    repeat (20) begin
      @(negedge clk);
      key = {$urandom(), $urandom(), $urandom(), $urandom()};
      plaintext = {$urandom(), $urandom(), $urandom(), $urandom()};
    end
    chk("zero_hold", cyphertext, CZ);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_enc_core.md
AES_ENC_CORE -- requirements
Module: aes_enc_core

Interface
REQ-001 Parameter: K, 128, key length in bits; only 128 is legal, and any other value SHALL trigger an elaboration error.
REQ-002 Port: clk  input  1  system clock; the block SHALL use this clock directly, with no derived slow clock.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  request to encrypt; sampled on rising clk.
REQ-005 Port: key  input  K  cipher key; words w[0..3] = [127:96],[95:64],[63:32],[31:0].
REQ-006 Port: plaintext  input  128  message; byte [127:120] = S0,0, column-major, same packing as key.
REQ-007 Port: busy  output  1  high while an encryption is in progress.
REQ-008 Port: done  output  1  single-cycle pulse marking cyphertext valid.
REQ-009 Port: cyphertext  output  128  encrypted block; same packing as plaintext.

Function
REQ-010 FSM states SHALL be IDLE, ROUND and DONE.
REQ-011 IDLE or DONE with start=1: the block SHALL latch the key into the round-key register, load state <= plaintext ^ key, set round=1, and go to ROUND.
REQ-012 IDLE with start=0: the block SHALL hold, and outputs SHALL remain unchanged.
REQ-013 ROUND, round 1..9: each clock SHALL apply SubBytes, ShiftRows, MixColumns and AddRoundKey with the next round key, then increment round.
REQ-014 ROUND, round 10: the block SHALL apply SubBytes, ShiftRows and AddRoundKey with no MixColumns, write the result to cyphertext, and go to DONE.
REQ-015 Key expansion SHALL be on the fly, one round key per cycle: w'[0] = w[0] ^ SubWord(RotWord(w[3])) ^ {Rcon[round],24'h0}; w'[i] = w'[i-1] ^ w[i] for i = 1..3.
REQ-016 The Rcon sequence for rounds 1..10 SHALL be 01,02,04,08,10,20,40,80,1B,36.
REQ-017 MixColumns SHALL use GF(2^8) with polynomial 0x11B; xtime(b) = (b<<1) ^ (b[7] ? 8'h1B : 0), truncated to 8 bits.
REQ-018 Latency: start sampled at edge N SHALL produce done=1 and a valid cyphertext during the cycle after edge N+10.
REQ-019 busy SHALL be 1 from edge N to edge N+10, and 0 in IDLE and DONE.
REQ-020 done SHALL be 1 only in DONE, for exactly one cycle; DONE SHALL go to IDLE when start=0.
REQ-021 start while busy=1 SHALL be ignored; key and plaintext changes while busy SHALL have no effect on the result.
REQ-022 cyphertext SHALL hold its value until the next round-10 write; it SHALL NOT change on start.
REQ-023 Back-to-back: start=1 during DONE SHALL begin a new encryption with no idle cycle, giving a throughput of one block per 11 cycles.
REQ-024 The round counter is 4 bits and SHALL never exceed 10; values 0 and 11..15 SHALL be unreachable.

Reset
REQ-025 Asserting reset SHALL immediately force state=IDLE, round=0, busy=0, done=0, cyphertext=0, and clear the state and key registers.
REQ-026 Reset mid-operation SHALL abort the operation with no done pulse; the first start after deassertion SHALL behave as from power-up.
REQ-027 start coincident with the first edge after reset deassertion SHALL be accepted.

Structure
REQ-028 Shared package aes_pkg SHALL hold the FSM state enum, NR=10, the Rcon table, and the xtime/MixColumns functions.
REQ-029 The S-box SHALL be a single combinational sub-module aes_sbox (8-bit in, 8-bit out); it SHALL be instantiated 16x for the state and 4x for SubWord.
REQ-030 ShiftRows, MixColumns and AddRoundKey SHALL be combinational logic inside aes_enc_core; no other sub-modules.

Verification
REQ-031 FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, plaintext 3243f6a8885a308d313198a2e0370734 -> cyphertext 3925841d02dc09fbdc118597196a0b32, with done exactly 11 cycles after the start edge.
REQ-032 FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-033 Back-to-back: C.1 start, then App. B start held during DONE -> both results correct, and the second done arrives 11 cycles after the first.
REQ-034 Hold start=1 and change key and plaintext during rounds -> result equals the original vector, with only one done per accepted start.
REQ-035 Assert reset at round 5 -> busy=0 and cyphertext=0 immediately, no done pulse; rerunning App. B afterwards -> correct result.
REQ-036 Key and plaintext all zeros -> 66e94bd4ef8a2c3b884cfa59ca342b2e; cyphertext held unchanged for 20 idle cycles.
